// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the camera-path SDRAM arbiter.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd1,
        WAIT = 3'd2,
        RD   = 3'd3,
        WR   = 3'd4
    } state_e;

    localparam int PRIO_WR  = 0;
    localparam int PRIO_ALT = 1;

    // Counter/index width that stays at least 1 bit for degenerate parameter values.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/burst_pop_seq.sv
// Segmented pop generator: XFER_LEN pops to one channel, in runs of SEG_LEN
// separated by SEG_GAP idle cycles, started by a one-cycle start pulse.
module burst_pop_seq
    import sdram_arb_pkg::*;
#(
    parameter int NUM_WR_CH = 2,
    parameter int XFER_LEN  = 640,
    parameter int SEG_LEN   = 256,
    parameter int SEG_GAP   = 3,
    parameter int CH_W      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CH_W-1:0]      ch,
    output logic [NUM_WR_CH-1:0] pop,
    output logic                 busy
);

    localparam int CNT_W = clog2_min1(XFER_LEN + 1);
    localparam int SEG_W = clog2_min1(SEG_LEN + 1);
    localparam int GAP_W = clog2_min1(SEG_GAP + 1);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(XFER_LEN - 1);
    localparam logic [SEG_W-1:0] LAST_SEG  = SEG_W'(SEG_LEN - 1);
    localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(SEG_GAP - 1);

    logic             busy_q;
    logic             in_gap;
    logic [CH_W-1:0]  ch_q;
    logic [CNT_W-1:0] word_cnt;
    logic [SEG_W-1:0] seg_cnt;
    logic [GAP_W-1:0] gap_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            in_gap   <= 1'b0;
            ch_q     <= '0;
            word_cnt <= '0;
            seg_cnt  <= '0;
            gap_cnt  <= '0;
        end else if (!busy_q) begin
            if (start) begin
                busy_q   <= 1'b1;
                in_gap   <= 1'b0;
                ch_q     <= ch;
                word_cnt <= '0;
                seg_cnt  <= '0;
                gap_cnt  <= '0;
            end
        end else if (in_gap) begin
            if (gap_cnt == LAST_GAP) begin
                in_gap  <= 1'b0;
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end else if (word_cnt == LAST_WORD) begin
            // Final pop: no trailing gap, even if it also ends a segment.
            busy_q <= 1'b0;
        end else begin
            word_cnt <= word_cnt + 1'b1;
            if (seg_cnt == LAST_SEG) begin
                seg_cnt <= '0;
                in_gap  <= (SEG_GAP > 0);
            end else begin
                seg_cnt <= seg_cnt + 1'b1;
            end
        end
    end

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        pop = '0;
        if (busy_q && !in_gap) pop[ch_q] = 1'b1;
    end

    assign busy = busy_q;

endmodule

// File: rtl/sdram_arb_fsm.sv
// SDRAM access arbiter: round-robin write bursts from the input FIFOs and
// camera-paced read bursts to the output FIFO.
module sdram_arb_fsm
    import sdram_arb_pkg::*;
#(
    parameter int NUM_WR_CH  = 2,
    parameter int WR_USEDW_W = 10,
    parameter int RD_USEDW_W = 12,
    parameter int WR_THRESH  = 600,
    parameter int RD_THRESH  = 1100,
    parameter int XFER_LEN   = 640,
    parameter int SEG_LEN    = 256,
    parameter int SEG_GAP    = 3,
    parameter int PRIO_MODE  = PRIO_WR
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clk_cam,
    input  logic                              VSYNC_cam,
    input  logic [NUM_WR_CH*WR_USEDW_W-1:0]   input_wrusedw,
    input  logic [RD_USEDW_W-1:0]             output_rdusedw,
    input  logic                              sd_ready,
    input  logic                              stop_capt,
    output logic                              p_VSYNC_cam,
    output logic                              wr_strobe,
    output logic [clog2_min1(NUM_WR_CH)-1:0]  wr_ch,
    output logic                              rd_strobe,
    output logic [NUM_WR_CH-1:0]              rd_input_fifo,
    output logic [2:0]                        state_o,
    output logic                              pop_err
);

    localparam int CH_W = clog2_min1(NUM_WR_CH);
    localparam logic [CH_W-1:0]       LAST_CH = CH_W'(NUM_WR_CH - 1);
    localparam logic [WR_USEDW_W-1:0] WR_TH   = WR_USEDW_W'(WR_THRESH);
    localparam logic [RD_USEDW_W-1:0] RD_TH   = RD_USEDW_W'(RD_THRESH);

    state_e cs, ns;
    logic [1:0] cam_sh, vs_sh;
    logic cam_tick, last_wr, seq_busy, wr_req, rd_req;
    logic found_hi, found_lo;
    logic [CH_W-1:0] rr_ptr, sel, sel_hi, sel_lo;
    logic [NUM_WR_CH-1:0] ch_req;
    logic [WR_USEDW_W-1:0] usedw [NUM_WR_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cam_sh      <= '0;
            vs_sh       <= '0;
            cam_tick    <= 1'b0;
            p_VSYNC_cam <= 1'b0;
        end else begin
            cam_sh      <= {cam_sh[0], clk_cam};
            vs_sh       <= {vs_sh[0], VSYNC_cam};
            cam_tick    <= cam_sh[0] & ~cam_sh[1];
            p_VSYNC_cam <= vs_sh[0] & ~vs_sh[1];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WR_CH; i++) begin
            usedw[i]  = input_wrusedw[i*WR_USEDW_W +: WR_USEDW_W];
            ch_req[i] = (usedw[i] >= WR_TH);
        end
    end

    // Lowest requester at/after the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = NUM_WR_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                found_lo = 1'b1;
                sel_lo   = CH_W'(i);
                if (CH_W'(i) >= rr_ptr) begin
                    found_hi = 1'b1;
                    sel_hi   = CH_W'(i);
                end
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
    end

    assign wr_req = found_lo && sd_ready && !stop_capt && !seq_busy;
    assign rd_req = (output_rdusedw <= RD_TH) && cam_tick && sd_ready;

    always_comb begin
        ns = cs;
        case (cs)
            IDLE: ns = WAIT;
            WAIT: begin
                if (wr_req && rd_req)
                    ns = (PRIO_MODE == PRIO_ALT && last_wr) ? RD : WR;
                else if (wr_req)
                    ns = WR;
                else if (rd_req)
                    ns = RD;
            end
            WR, RD: if (!sd_ready) ns = WAIT;
            default: ns = IDLE;
        endcase
    end

    assign wr_strobe = (cs == WAIT) && (ns == WR);
    assign rd_strobe = (cs == WAIT) && (ns == RD);
    assign state_o   = cs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs      <= IDLE;
            wr_ch   <= '0;
            rr_ptr  <= '0;
            last_wr <= 1'b0;
            pop_err <= 1'b0;
        end else begin
            cs <= ns;
            if (wr_strobe) begin
                wr_ch   <= sel;
                rr_ptr  <= (sel == LAST_CH) ? '0 : sel + 1'b1;
                last_wr <= 1'b1;
            end else if (rd_strobe) begin
                last_wr <= 1'b0;
            end
            if ((|rd_input_fifo) && (usedw[wr_ch] == '0)) pop_err <= 1'b1;
        end
    end

    burst_pop_seq #(
        .NUM_WR_CH (NUM_WR_CH),
        .XFER_LEN  (XFER_LEN),
        .SEG_LEN   (SEG_LEN),
        .SEG_GAP   (SEG_GAP),
        .CH_W      (CH_W)
    ) u_pop_seq (
        .clk   (clk),
        .rst   (rst),
        .start (wr_strobe),
        .ch    (sel),
        .pop   (rd_input_fifo),
        .busy  (seq_busy)
    );

endmodule
